// File: rtl/lea_128bit_result_serializer.sv
// Serializes one 128-bit LEA result block into four 32-bit words over valid/ready.
// Holds one block at a time and pulses Done one cycle after the last word is taken.
module lea_128bit_result_serializer #(
    parameter bit LSW_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] i_din,
    input  logic         i_ld,
    input  logic         i_clr,
    input  logic         i_dready,
    output logic         o_busy,
    output logic [31:0]  o_dout,
    output logic         o_dvalid,
    output logic         o_dlast,
    output logic         o_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [1:0]    r_cnt;
    logic [127:0]  r_hold;
    logic [31:0]   r_dout;
    logic          r_done;
    logic          w_load;
    logic          w_xfer;

    // Word idx of a block in transmit order.
    function automatic logic [31:0] pick_word(input logic [127:0] blk, input logic [1:0] idx);
        logic [1:0] pos;
        pos = LSW_FIRST ? idx : (2'd3 - idx);
        return blk[{pos, 5'b0} +: 32];
    endfunction

    assign w_load = (r_state == IDLE) && i_ld && !i_clr;
    assign w_xfer = (r_state == SEND) && i_dready && !i_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (i_clr) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_ld) w_next_state = SEND;
                SEND:    if (i_dready && (r_cnt == 2'd3)) w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_hold <= 128'd0;
            r_dout <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_xfer && (r_cnt == 2'd3);
            if (i_clr) begin
                r_cnt <= 2'd0;
            end else if (w_load) begin
                r_hold <= i_din;
                r_cnt  <= 2'd0;
                r_dout <= pick_word(i_din, 2'd0);
            end else if (w_xfer) begin
                // Counter wraps 3 -> 0 on the last word; Dout keeps the last word in IDLE.
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt != 2'd3) r_dout <= pick_word(r_hold, r_cnt + 2'd1);
            end
        end
    end

    assign o_busy   = (r_state == SEND);
    assign o_dvalid = (r_state == SEND);
    assign o_dlast  = (r_state == SEND) && (r_cnt == 2'd3);
    assign o_dout   = r_dout;
    assign o_done   = r_done;

endmodule

// File: tb/tb_lea_128bit_result_serializer.sv
// Scoreboard bench for the result serializer; both word orders run side by side
// from the same stimulus and are checked against a block-level reference model.
module tb_lea_128bit_result_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] i_din = '0;
    logic         i_ld = 1'b0;
    logic         i_clr = 1'b0;
    logic         i_dready = 1'b0;

    logic         busy   [2];
    logic [31:0]  dout   [2];
    logic         dvalid [2];
    logic         dlast  [2];
    logic         done   [2];

    int tests = 0;
    int fails = 0;

    // Reference model state: expected blocks, word index, busy flag, pending Done.
    logic [127:0] exp_q[$];
    int           m_w = 0;
    bit           m_busy = 1'b0;
    bit           done_pend = 1'b0;

    always #5 clk = ~clk;

    // Instance 0 sends the low word first, instance 1 the high word first.
    lea_128bit_result_serializer #(.LSW_FIRST(1'b1)) u_dut_lsw (
        .clk(clk), .rst(rst), .i_din(i_din), .i_ld(i_ld), .i_clr(i_clr), .i_dready(i_dready),
        .o_busy(busy[0]), .o_dout(dout[0]), .o_dvalid(dvalid[0]), .o_dlast(dlast[0]), .o_done(done[0])
    );
    lea_128bit_result_serializer #(.LSW_FIRST(1'b0)) u_dut_msw (
        .clk(clk), .rst(rst), .i_din(i_din), .i_ld(i_ld), .i_clr(i_clr), .i_dready(i_dready),
        .o_busy(busy[1]), .o_dout(dout[1]), .o_dvalid(dvalid[1]), .o_dlast(dlast[1]), .o_done(done[1])
    );

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [127:0] blk, input int w, input bit lsw);
        int idx;
        idx = lsw ? w : 3 - w;
        return blk[idx*32 +: 32];
    endfunction

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check(dout[d] == 32'd0,  $sformatf("%s dout[%0d]", tag, d),   dout[d], 0);
            check(dvalid[d] == 1'b0, $sformatf("%s dvalid[%0d]", tag, d), dvalid[d], 0);
            check(busy[d] == 1'b0,   $sformatf("%s busy[%0d]", tag, d),   busy[d], 0);
            check(dlast[d] == 1'b0,  $sformatf("%s dlast[%0d]", tag, d),  dlast[d], 0);
            check(done[d] == 1'b0,   $sformatf("%s done[%0d]", tag, d),   done[d], 0);
        end
    endtask

    // Monitor: compare at the falling edge, then predict the effect of the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            check_zero("reset");
            exp_q.delete();
            m_w       = 0;
            m_busy    = 1'b0;
            done_pend = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                check(done[d] == done_pend, $sformatf("done[%0d]", d), done[d], done_pend);
                check(busy[d] == m_busy, $sformatf("busy[%0d]", d), busy[d], m_busy);
                check(dvalid[d] == m_busy, $sformatf("dvalid[%0d]", d), dvalid[d], m_busy);
                check(dlast[d] == (m_busy && m_w == 3), $sformatf("dlast[%0d]", d), dlast[d], m_busy && m_w == 3);
                check(!(busy[d] && done[d]), $sformatf("busy_and_done[%0d]", d), {busy[d], done[d]}, 0);
                if (m_busy && exp_q.size() > 0)
                    check(dout[d] == exp_word(exp_q[0], m_w, d == 0),
                          $sformatf("dout[%0d] word %0d", d, m_w), dout[d], exp_word(exp_q[0], m_w, d == 0));
            end
            done_pend = 1'b0;
            if (i_clr) begin
                if (m_busy && exp_q.size() > 0) void'(exp_q.pop_front());
                m_busy = 1'b0;
                m_w    = 0;
            end else if (m_busy) begin
                if (i_dready) begin
                    if (m_w == 3) begin
                        void'(exp_q.pop_front());
                        m_w       = 0;
                        m_busy    = 1'b0;
                        done_pend = 1'b1;
                    end else begin
                        m_w++;
                    end
                end
            end else if (i_ld) begin
                exp_q.push_back(i_din);
                m_busy = 1'b1;
                m_w    = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] blk);
        i_din = blk;
        i_ld  = 1'b1;
        step();
        i_ld  = 1'b0;
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        bit bp [7];
        bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        #2 check_zero("por");
        step();
        step();
        rst = 1'b0;

        // Full-rate transfer of the reference block in both word orders.
        i_dready = 1'b1;
        load(128'h00112233_44556677_8899AABB_CCDDEEFF);
        repeat (5) step();

        // Back-pressure pattern 1,0,0,1,0,1,1.
        load(rand_blk());
        for (int i = 0; i < 7; i++) begin
            i_dready = bp[i];
            step();
        end
        i_dready = 1'b1;
        repeat (3) step();

        // Ld while sending is ignored; next block loaded at the earliest legal edge.
        load(rand_blk());
        i_din = {128{1'b1}};
        i_ld  = 1'b1;
        repeat (3) step();
        i_ld = 1'b0;
        step();
        load(rand_blk());
        repeat (5) step();

        // Clr at cnt=2 together with Dready and Ld.
        load(rand_blk());
        repeat (2) step();
        i_clr = 1'b1;
        i_ld  = 1'b1;
        i_din = rand_blk();
        step();
        i_clr = 1'b0;
        i_ld  = 1'b0;
        step();
        load(rand_blk());
        repeat (5) step();

        // Asynchronous reset in the middle of a cycle at cnt=1.
        load(128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C);
        step();
        #1 rst = 1'b1;
        #1 check_zero("async_rst");
        step();
        rst = 1'b0;
        repeat (2) step();
        load(rand_blk());
        repeat (5) step();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            i_dready = ($urandom_range(0, 3) != 0);
            i_ld     = ($urandom_range(0, 2) == 0);
            i_clr    = ($urandom_range(0, 24) == 0);
            i_din    = rand_blk();
            step();
        end

        i_ld     = 1'b0;
        i_clr    = 1'b0;
        i_dready = 1'b1;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
